// File: rtl/uart_mem_bridge_pkg.sv
// Shared types and constants for the UART memory bridge.
package uart_mem_bridge_pkg;

  // Command opcode carried in cmd[7:4].
  typedef enum logic [3:0] {
    OP_WRITE = 4'h1,
    OP_READ  = 4'h2,
    OP_RUN   = 4'h3,
    OP_HALT  = 4'h4,
    OP_PING  = 4'h5
  } op_t;

  // Frame-level protocol state.
  typedef enum logic [3:0] {
    IDLE,
    HDR_ADDR,
    HDR_LEN,
    WR_DATA,
    WR_MEM,
    RD_REQ,
    RD_WAIT,
    RD_SEND,
    SEND_SUM,
    SEND_BYTE
  } state_t;

  localparam logic [7:0] RSP_ACK = 8'hA5;
  localparam logic [7:0] RSP_ERR = 8'hEE;

endpackage

// File: rtl/bridge_timeout.sv
// Idle watchdog for a partially received frame: fires after TIMEOUT_CYC
// consecutive armed cycles without an rx byte.
module bridge_timeout #(
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic run_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] count;

  // A byte arriving in the same cycle always wins over expiry.
  assign expired_o = run_i && !clear_i && (count == CNT_W'(TIMEOUT_CYC - 1));

  // Count idle armed cycles; any rx transfer or leaving the armed states restarts.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (clear_i || !run_i) begin
      count <= '0;
    end else if (!expired_o) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_mem_bridge.sv
// UART framed-protocol loader/debug engine: byte writes and reads on NUM_CH
// memory targets, CPU reset control, checksum, frame timeout and error reply.
module uart_mem_bridge
  import uart_mem_bridge_pkg::*;
#(
  parameter int         XLEN        = 32,
  parameter int         NUM_CH      = 2,
  parameter int         RD_LAT      = 1,
  parameter int         TIMEOUT_CYC = 2000000,
  parameter logic [7:0] VERSION     = 8'h21
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [7:0]             rx_data_i,
  input  logic                   rx_vld_i,
  output logic                   rx_rdy_o,
  output logic [7:0]             tx_data_o,
  output logic                   tx_vld_o,
  input  logic                   tx_rdy_i,
  output logic                   cpu_rst_o,
  output logic                   mem_own_o,
  output logic [NUM_CH-1:0]      mem_ch_o,
  output logic [XLEN-1:0]        mem_addr_o,
  output logic                   mem_wr_en_o,
  output logic [XLEN-1:0]        mem_wr_data_o,
  output logic [XLEN/8-1:0]      mem_byte_en_o,
  output logic                   mem_rd_en_o,
  input  logic [NUM_CH*XLEN-1:0] mem_rd_data_i
);

  localparam int NB    = XLEN / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t           state;
  logic             is_read;
  logic [3:0]       ch;
  logic [XLEN-1:0]  addr;
  logic [XLEN-1:0]  len;
  logic [7:0]       sum;
  logic [IDX_W-1:0] hdr_idx;
  logic [LAT_W-1:0] lat_cnt;

  logic             rx_fire;
  logic             tx_fire;
  logic             hdr_last;
  logic             ch_ok;
  logic             timed_out;
  logic             timer_run;
  op_t              cmd_op;
  logic [3:0]       cmd_ch;
  logic [XLEN-1:0]  hdr_word;
  logic [XLEN-1:0]  next_addr;
  logic [IDX_W-1:0] lane;
  logic [7:0]       rd_byte;

  // Byte-lane strobe for a byte address.
  function automatic logic [NB-1:0] lane_mask(input logic [XLEN-1:0] a);
    return (NB > 1) ? (NB'(1) << a[IDX_W-1:0]) : '1;
  endfunction

  assign rx_fire   = rx_vld_i && rx_rdy_o;
  assign tx_fire   = tx_vld_o && tx_rdy_i;
  assign cmd_op    = op_t'(rx_data_i[7:4]);
  assign cmd_ch    = rx_data_i[3:0];
  assign ch_ok     = int'(cmd_ch) < NUM_CH;
  assign hdr_last  = (hdr_idx == IDX_W'(NB - 1));
  assign next_addr = addr + XLEN'(1);
  assign lane      = (NB > 1) ? addr[IDX_W-1:0] : '0;
  assign rd_byte   = mem_rd_data_i[int'(ch)*XLEN + int'(lane)*8 +: 8];
  assign mem_own_o = cpu_rst_o;
  assign timer_run = (state == HDR_ADDR) || (state == HDR_LEN) || (state == WR_DATA);

  // Header word being assembled: the current field with this rx byte merged into its lane.
  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    hdr_word = (state == HDR_LEN) ? len : addr;
    hdr_word[hdr_idx*8 +: 8] = rx_data_i;
  end

  bridge_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (rx_fire),
    .run_i     (timer_run),
    .expired_o (timed_out)
  );

  // Protocol FSM with all outputs registered.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      is_read       <= 1'b0;
      ch            <= '0;
      addr          <= '0;
      len           <= '0;
      sum           <= '0;
      hdr_idx       <= '0;
      lat_cnt       <= '0;
      rx_rdy_o      <= 1'b0;
      tx_data_o     <= '0;
      tx_vld_o      <= 1'b0;
      cpu_rst_o     <= 1'b1;
      mem_ch_o      <= '0;
      mem_addr_o    <= '0;
      mem_wr_en_o   <= 1'b0;
      mem_wr_data_o <= '0;
      mem_byte_en_o <= '0;
      mem_rd_en_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_fire) begin
            sum     <= '0;
            hdr_idx <= '0;
            ch      <= cmd_ch;
            if ((cmd_op == OP_WRITE || cmd_op == OP_READ) && ch_ok && cpu_rst_o) begin
              is_read <= (cmd_op == OP_READ);
              state   <= HDR_ADDR;
            end else begin
              rx_rdy_o <= 1'b0;
              tx_vld_o <= 1'b1;
              state    <= SEND_BYTE;
              case (cmd_op)
                OP_RUN: begin
                  cpu_rst_o <= 1'b0;
                  tx_data_o <= RSP_ACK;
                end
                OP_HALT: begin
                  cpu_rst_o <= 1'b1;
                  tx_data_o <= RSP_ACK;
                end
                OP_PING: tx_data_o <= VERSION;
                default: tx_data_o <= RSP_ERR;
              endcase
            end
          end else begin
            rx_rdy_o <= 1'b1;
          end
        end

        HDR_ADDR: begin
          if (rx_fire) begin
            addr <= hdr_word;
            if (hdr_last) begin
              hdr_idx <= '0;
              state   <= HDR_LEN;
            end else begin
              hdr_idx <= hdr_idx + IDX_W'(1);
            end
          end else if (timed_out) begin
            state <= IDLE;
          end
        end

        HDR_LEN: begin
          if (rx_fire) begin
            len <= hdr_word;
            if (!hdr_last) begin
              hdr_idx <= hdr_idx + IDX_W'(1);
            end else if (hdr_word == '0) begin
              rx_rdy_o  <= 1'b0;
              tx_vld_o  <= 1'b1;
              tx_data_o <= sum;
              state     <= SEND_SUM;
            end else if (is_read) begin
              rx_rdy_o      <= 1'b0;
              mem_rd_en_o   <= 1'b1;
              mem_ch_o      <= NUM_CH'(1) << ch;
              mem_addr_o    <= addr;
              mem_byte_en_o <= lane_mask(addr);
              state         <= RD_REQ;
            end else begin
              state <= WR_DATA;
            end
          end else if (timed_out) begin
            state <= IDLE;
          end
        end

        WR_DATA: begin
          if (rx_fire) begin
            rx_rdy_o      <= 1'b0;
            mem_wr_en_o   <= 1'b1;
            mem_ch_o      <= NUM_CH'(1) << ch;
            mem_addr_o    <= addr;
            mem_wr_data_o <= {NB{rx_data_i}};
            mem_byte_en_o <= lane_mask(addr);
            sum           <= sum + rx_data_i;
            state         <= WR_MEM;
          end else if (timed_out) begin
            state <= IDLE;
          end
        end

        WR_MEM: begin
          mem_wr_en_o   <= 1'b0;
          mem_ch_o      <= '0;
          mem_byte_en_o <= '0;
          addr          <= next_addr;
          len           <= len - XLEN'(1);
          if (len == XLEN'(1)) begin
            tx_vld_o  <= 1'b1;
            tx_data_o <= sum;
            state     <= SEND_SUM;
          end else begin
            rx_rdy_o <= 1'b1;
            state    <= WR_DATA;
          end
        end

        RD_REQ: begin
          mem_rd_en_o   <= 1'b0;
          mem_ch_o      <= '0;
          mem_byte_en_o <= '0;
          lat_cnt       <= LAT_W'(RD_LAT - 1);
          state         <= RD_WAIT;
        end

        RD_WAIT: begin
          if (lat_cnt == '0) begin
            tx_data_o <= rd_byte;
            tx_vld_o  <= 1'b1;
            sum       <= sum + rd_byte;
            state     <= RD_SEND;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end

        RD_SEND: begin
          if (tx_fire) begin
            addr <= next_addr;
            len  <= len - XLEN'(1);
            if (len == XLEN'(1)) begin
              tx_data_o <= sum;
              state     <= SEND_SUM;
            end else begin
              tx_vld_o      <= 1'b0;
              mem_rd_en_o   <= 1'b1;
              mem_ch_o      <= NUM_CH'(1) << ch;
              mem_addr_o    <= next_addr;
              mem_byte_en_o <= lane_mask(next_addr);
              state         <= RD_REQ;
            end
          end
        end

        SEND_SUM, SEND_BYTE: begin
          if (tx_fire) begin
            tx_vld_o <= 1'b0;
            rx_rdy_o <= 1'b1;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Self-checking bench for uart_mem_bridge: table of command frames plus
// hand-written sequences for backpressure, timeout and mid-frame reset.
module tb_uart_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_vld;
  logic        rx_rdy;
  logic [7:0]  tx_data;
  logic        tx_vld;
  logic        tx_rdy;
  logic        cpu_rst;
  logic        mem_own;
  logic [1:0]  mem_ch;
  logic [31:0] mem_addr;
  logic        mem_wr_en;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_byte_en;
  logic        mem_rd_en;
  logic [63:0] mem_rd_data = '0;

  uart_mem_bridge #(
    .XLEN        (32),
    .NUM_CH      (2),
    .RD_LAT      (1),
    .TIMEOUT_CYC (200),
    .VERSION     (8'h21)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .rx_data_i     (rx_data),
    .rx_vld_i      (rx_vld),
    .rx_rdy_o      (rx_rdy),
    .tx_data_o     (tx_data),
    .tx_vld_o      (tx_vld),
    .tx_rdy_i      (tx_rdy),
    .cpu_rst_o     (cpu_rst),
    .mem_own_o     (mem_own),
    .mem_ch_o      (mem_ch),
    .mem_addr_o    (mem_addr),
    .mem_wr_en_o   (mem_wr_en),
    .mem_wr_data_o (mem_wr_data),
    .mem_byte_en_o (mem_byte_en),
    .mem_rd_en_o   (mem_rd_en),
    .mem_rd_data_i (mem_rd_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  ch;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  typedef struct {
    string       name;
    logic [95:0] req;    // request bytes, first byte most significant
    int          req_n;
    logic [31:0] rsp;    // expected reply bytes, first byte most significant
    int          rsp_n;
    int          wr_n;
    int          rd_n;
    logic        cpu;
  } vec_t;

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          n_rd   = 0;
  wr_t         wr_log[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  ram [2][16];
  vec_t        vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference RAM: ch x low 4 address bits is enough for the addresses used here.
  function automatic logic [31:0] rd_word(input int c, input logic [31:0] a);
    logic [31:0] w;
    w = 32'hC3C3_C3C3;
    w[a[1:0]*8 +: 8] = ram[c][a[3:0]];
    return w;
  endfunction

  // Synchronous read port with one cycle of latency.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      for (int c = 0; c < 2; c++) begin
        if (mem_ch[c]) mem_rd_data[c*32 +: 32] <= rd_word(c, mem_addr);
      end
    end
  end

  // Observe outputs mid-cycle: tx handshakes, write strobes and read strobes.
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_vld && tx_rdy) tx_q.push_back(tx_data);
      if (mem_wr_en) begin
        wr_log.push_back('{mem_ch, mem_addr, mem_wr_data, mem_byte_en});
        for (int c = 0; c < 2; c++) begin
          if (mem_ch[c]) ram[c][mem_addr[3:0]] <= mem_wr_data[7:0];
        end
      end
      if (mem_rd_en) n_rd <= n_rd + 1;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    rx_data = b;
    rx_vld  = 1'b1;
    while (!done) begin
      @(negedge clk);
      done = rx_rdy;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 1000) begin
        check("rx_accept", rx_rdy, 1);
        done = 1'b1;
      end
    end
    rx_vld = 1'b0;
  endtask

  task automatic wait_tx(input int n);
    int k;
    k = 0;
    while (tx_q.size() < n && k < 400) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (tx_q.size() < n) check("tx_wait", tx_q.size(), n);
  endtask

  task automatic expect_tx(input string name, input logic [7:0] b);
    logic [7:0] got;
    got = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hxx;
    check(name, got, b);
  endtask

  task automatic quiet(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    wr_t exp_wr[5];
    int  wr0;
    int  rd0;

    vecs[0]  = '{"ping",      96'h50,                           1,  32'h21,        1, 0, 0, 1'b1};
    vecs[1]  = '{"wr_burst",  96'h11_03000000_03000000_102030, 12,  32'h60,        1, 3, 0, 1'b1};
    vecs[2]  = '{"rd_back",   96'h21_03000000_03000000,         9,  32'h10203060,  4, 0, 3, 1'b1};
    vecs[3]  = '{"bad_ch_wr", 96'h15,                           1,  32'hEE,        1, 0, 0, 1'b1};
    vecs[4]  = '{"bad_ch_rd", 96'h25,                           1,  32'hEE,        1, 0, 0, 1'b1};
    vecs[5]  = '{"bad_op7",   96'h70,                           1,  32'hEE,        1, 0, 0, 1'b1};
    vecs[6]  = '{"len0_wr",   96'h11_00000000_00000000,         9,  32'h00,        1, 0, 0, 1'b1};
    vecs[7]  = '{"len0_rd",   96'h21_00000000_00000000,         9,  32'h00,        1, 0, 0, 1'b1};
    vecs[8]  = '{"wrap_wr",   96'h10_FFFFFFFF_02000000_ABCD,   11,  32'h78,        1, 2, 0, 1'b1};
    vecs[9]  = '{"wrap_rd",   96'h20_FFFFFFFF_02000000,         9,  32'hABCD78,    3, 0, 2, 1'b1};
    vecs[10] = '{"halt0",     96'h40,                           1,  32'hA5,        1, 0, 0, 1'b1};
    vecs[11] = '{"run",       96'h30,                           1,  32'hA5,        1, 0, 0, 1'b0};
    vecs[12] = '{"wr_run",    96'h10,                           1,  32'hEE,        1, 0, 0, 1'b0};
    vecs[13] = '{"rd_run",    96'h20,                           1,  32'hEE,        1, 0, 0, 1'b0};
    vecs[14] = '{"halt1",     96'h40,                           1,  32'hA5,        1, 0, 0, 1'b1};
    vecs[15] = '{"bad_op0",   96'h00,                           1,  32'hEE,        1, 0, 0, 1'b1};

    exp_wr[0] = '{2'b10, 32'h0000_0003, 32'h1010_1010, 4'b1000};
    exp_wr[1] = '{2'b10, 32'h0000_0004, 32'h2020_2020, 4'b0001};
    exp_wr[2] = '{2'b10, 32'h0000_0005, 32'h3030_3030, 4'b0010};
    exp_wr[3] = '{2'b01, 32'hFFFF_FFFF, 32'hABAB_ABAB, 4'b1000};
    exp_wr[4] = '{2'b01, 32'h0000_0000, 32'hCDCD_CDCD, 4'b0001};

    // Reset state.
    rst     = 1'b1;
    rx_data = '0;
    rx_vld  = 1'b0;
    tx_rdy  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_mem_own", mem_own, 1);
    check("rst_rx_rdy", rx_rdy, 0);
    check("rst_tx_vld", tx_vld, 0);
    check("rst_mem_ch", mem_ch, 0);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_addr", mem_addr, 0);
    rst = 1'b0;
    quiet(1);
    check("idle_rx_rdy", rx_rdy, 1);

    // Table of complete frames.
    for (int v = 0; v < 16; v++) begin
      wr0 = wr_log.size();
      rd0 = n_rd;
      for (int i = 0; i < vecs[v].req_n; i++) begin
        send_byte(vecs[v].req[(vecs[v].req_n - 1 - i)*8 +: 8]);
      end
      wait_tx(vecs[v].rsp_n);
      for (int i = 0; i < vecs[v].rsp_n; i++) begin
        expect_tx({vecs[v].name, "_rsp"}, vecs[v].rsp[(vecs[v].rsp_n - 1 - i)*8 +: 8]);
      end
      quiet(8);
      check({vecs[v].name, "_extra_tx"}, tx_q.size(), 0);
      check({vecs[v].name, "_wr_cnt"}, wr_log.size() - wr0, vecs[v].wr_n);
      check({vecs[v].name, "_rd_cnt"}, n_rd - rd0, vecs[v].rd_n);
      check({vecs[v].name, "_cpu_rst"}, cpu_rst, vecs[v].cpu);
      check({vecs[v].name, "_mem_own"}, mem_own, vecs[v].cpu);
    end

    // Write strobes of the burst and of the wrapping write.
    check("wr_log_size", wr_log.size(), 5);
    for (int i = 0; i < 5 && i < wr_log.size(); i++) begin
      check($sformatf("wr%0d_ch", i), wr_log[i].ch, exp_wr[i].ch);
      check($sformatf("wr%0d_addr", i), wr_log[i].addr, exp_wr[i].addr);
      check($sformatf("wr%0d_data", i), wr_log[i].data, exp_wr[i].data);
      check($sformatf("wr%0d_be", i), wr_log[i].be, exp_wr[i].be);
    end

    // Read back with tx backpressure: the first byte must be held, nothing lost.
    rd0    = n_rd;
    tx_rdy = 1'b0;
    send_byte(8'h21);
    for (int i = 0; i < 4; i++) send_byte(i == 0 ? 8'h03 : 8'h00);
    for (int i = 0; i < 4; i++) send_byte(i == 0 ? 8'h03 : 8'h00);
    quiet(50);
    check("bp_tx_vld", tx_vld, 1);
    check("bp_tx_data", tx_data, 8'h10);
    check("bp_no_tx", tx_q.size(), 0);
    check("bp_one_read", n_rd - rd0, 1);
    tx_rdy = 1'b1;
    wait_tx(4);
    expect_tx("bp_rsp0", 8'h10);
    expect_tx("bp_rsp1", 8'h20);
    expect_tx("bp_rsp2", 8'h30);
    expect_tx("bp_sum", 8'h60);

    // Frame timeout after two header bytes: silent abort, then PING still answers.
    wr0 = wr_log.size();
    send_byte(8'h11);
    send_byte(8'h03);
    send_byte(8'h00);
    quiet(250);
    check("to_no_tx", tx_q.size(), 0);
    check("to_rx_rdy", rx_rdy, 1);
    check("to_no_wr", wr_log.size() - wr0, 0);
    send_byte(8'h50);
    wait_tx(1);
    expect_tx("to_ping", 8'h21);

    // Reset while waiting for the second data byte of a write.
    wr0 = wr_log.size();
    send_byte(8'h11);
    for (int i = 0; i < 4; i++) send_byte(i == 0 ? 8'h03 : 8'h00);
    for (int i = 0; i < 4; i++) send_byte(i == 0 ? 8'h03 : 8'h00);
    send_byte(8'h77);
    quiet(3);
    check("mid_addr_before", mem_addr, 32'h3);
    check("mid_rx_rdy_before", rx_rdy, 1);
    rst = 1'b1;
    #1;
    check("mid_cpu_rst", cpu_rst, 1);
    check("mid_mem_own", mem_own, 1);
    check("mid_rx_rdy", rx_rdy, 0);
    check("mid_tx_vld", tx_vld, 0);
    check("mid_mem_ch", mem_ch, 0);
    check("mid_addr", mem_addr, 0);
    check("mid_wr_data", mem_wr_data, 0);
    check("mid_byte_en", mem_byte_en, 0);
    check("mid_wr_en", mem_wr_en, 0);
    check("mid_rd_en", mem_rd_en, 0);
    quiet(2);
    rst = 1'b0;
    quiet(20);
    check("mid_no_tx", tx_q.size(), 0);
    check("mid_wr_cnt", wr_log.size() - wr0, 1);
    send_byte(8'h50);
    wait_tx(1);
    expect_tx("mid_ping", 8'h21);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
